// File: rtl/find_bw_edges.sv
// find_bw_edges: scans one sweep of dB samples and reports the left and right threshold crossings
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, threshold_i     begin a sweep (IDLE only); threshold latched at start
//   s_valid_i, s_ready_o     sample handshake (ready only while scanning)
//   s_val_i, s_bin_i         sample power (signed dB, Q.8) and its ascending bin index
//   left_*_o, right_*_o      bin/power pairs of the first rising and last falling crossing
//   left_found_o, right_found_o  crossing-valid flags
//   bw_o                     right_f2 - left_f1 when both edges exist and are ordered, else 0
//   valid_o, busy_o          one-cycle result strobe (DONE), scan-in-progress flag
//   peak_bin_o, peak_val_o   maximum sample of the sweep, only with FIND_BW_EDGES_PEAK_EN
module find_bw_edges #(
    parameter int ACCUM_WIDTH    = 18,
    parameter int FREQ_BIN_WIDTH = 9,
    parameter int NUM_BINS       = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [ACCUM_WIDTH-1:0]    threshold_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [ACCUM_WIDTH-1:0]    s_val_i,
    input  logic [FREQ_BIN_WIDTH-1:0] s_bin_i,
    output logic [FREQ_BIN_WIDTH-1:0] left_f1_o,
    output logic [FREQ_BIN_WIDTH-1:0] left_f2_o,
    output logic [FREQ_BIN_WIDTH-1:0] right_f1_o,
    output logic [FREQ_BIN_WIDTH-1:0] right_f2_o,
    output logic [ACCUM_WIDTH-1:0]    left_l1_o,
    output logic [ACCUM_WIDTH-1:0]    left_l2_o,
    output logic [ACCUM_WIDTH-1:0]    right_l1_o,
    output logic [ACCUM_WIDTH-1:0]    right_l2_o,
    output logic                      left_found_o,
    output logic                      right_found_o,
    output logic [FREQ_BIN_WIDTH-1:0] bw_o,
`ifdef FIND_BW_EDGES_PEAK_EN
    output logic [FREQ_BIN_WIDTH-1:0] peak_bin_o,
    output logic [ACCUM_WIDTH-1:0]    peak_val_o,
`endif
    output logic                      valid_o,
    output logic                      busy_o
);
    localparam int CNT_W = $clog2(NUM_BINS) + 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                    r_state, w_state_n;
    logic [CNT_W-1:0]          r_cnt;
    logic [ACCUM_WIDTH-1:0]    r_thr, r_prev_val;
    logic [FREQ_BIN_WIDTH-1:0] r_prev_bin;
    logic [FREQ_BIN_WIDTH-1:0] r_left_f1, r_left_f2, r_right_f1, r_right_f2, r_bw;
    logic [ACCUM_WIDTH-1:0]    r_left_l1, r_left_l2, r_right_l1, r_right_l2;
    logic                      r_left_found, r_right_found;
`ifdef FIND_BW_EDGES_PEAK_EN
    logic [FREQ_BIN_WIDTH-1:0] r_peak_bin;
    logic [ACCUM_WIDTH-1:0]    r_peak_val;
`endif

    logic                      w_start, w_acc, w_last, w_pair, w_rise, w_fall;
    logic                      w_c_above, w_p_above, w_lfd_n, w_rfd_n;
    logic [FREQ_BIN_WIDTH-1:0] w_lf1_n, w_rf2_n, w_bw_n;

    assign w_start   = (r_state == IDLE) && start_i;
    assign w_acc     = (r_state == SCAN) && s_valid_i;
    assign w_last    = w_acc && (r_cnt == CNT_W'(NUM_BINS - 1));
    assign w_pair    = w_acc && (r_cnt != '0);
    assign w_c_above = $signed(s_val_i) > $signed(r_thr);
    assign w_p_above = $signed(r_prev_val) > $signed(r_thr);
    // Only the first rising crossing is kept; every falling crossing overwrites.
    assign w_rise    = w_pair && !w_p_above && w_c_above && !r_left_found;
    assign w_fall    = w_pair && w_p_above && !w_c_above;

    // Bandwidth is registered on the last handshake, so it must see this cycle's edge updates.
    assign w_lf1_n = w_rise ? r_prev_bin : r_left_f1;
    assign w_rf2_n = w_fall ? s_bin_i : r_right_f2;
    assign w_lfd_n = r_left_found | w_rise;
    assign w_rfd_n = r_right_found | w_fall;
    assign w_bw_n  = (w_lfd_n && w_rfd_n && (w_rf2_n >= w_lf1_n)) ? w_rf2_n - w_lf1_n : '0;

    always_comb begin
        w_state_n = r_state;
        if (w_start)
            w_state_n = SCAN;
        else if (w_last)
            w_state_n = DONE;
        else if (r_state == DONE)
            w_state_n = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_thr         <= '0;
            r_prev_val    <= '0;
            r_prev_bin    <= '0;
            r_left_f1     <= '0;
            r_left_f2     <= '0;
            r_right_f1    <= '0;
            r_right_f2    <= '0;
            r_left_l1     <= '0;
            r_left_l2     <= '0;
            r_right_l1    <= '0;
            r_right_l2    <= '0;
            r_left_found  <= 1'b0;
            r_right_found <= 1'b0;
            r_bw          <= '0;
`ifdef FIND_BW_EDGES_PEAK_EN
            r_peak_bin    <= '0;
            r_peak_val    <= '0;
`endif
        end else begin
            r_state <= w_state_n;
            if (w_start) begin
                r_cnt         <= '0;
                r_thr         <= threshold_i;
                r_left_f1     <= '0;
                r_left_f2     <= '0;
                r_right_f1    <= '0;
                r_right_f2    <= '0;
                r_left_l1     <= '0;
                r_left_l2     <= '0;
                r_right_l1    <= '0;
                r_right_l2    <= '0;
                r_left_found  <= 1'b0;
                r_right_found <= 1'b0;
                r_bw          <= '0;
`ifdef FIND_BW_EDGES_PEAK_EN
                r_peak_bin    <= '0;
                r_peak_val    <= '0;
`endif
            end else if (w_acc) begin
                r_cnt      <= r_cnt + 1'b1;
                r_prev_val <= s_val_i;
                r_prev_bin <= s_bin_i;
                if (w_rise) begin
                    r_left_f1    <= r_prev_bin;
                    r_left_f2    <= s_bin_i;
                    r_left_l1    <= r_prev_val;
                    r_left_l2    <= s_val_i;
                    r_left_found <= 1'b1;
                end
                if (w_fall) begin
                    r_right_f1    <= r_prev_bin;
                    r_right_f2    <= s_bin_i;
                    r_right_l1    <= r_prev_val;
                    r_right_l2    <= s_val_i;
                    r_right_found <= 1'b1;
                end
                if (w_last)
                    r_bw <= w_bw_n;
`ifdef FIND_BW_EDGES_PEAK_EN
                // Strict compare keeps the first occurrence on ties.
                if ((r_cnt == '0) || ($signed(s_val_i) > $signed(r_peak_val))) begin
                    r_peak_bin <= s_bin_i;
                    r_peak_val <= s_val_i;
                end
`endif
            end
        end
    end

    assign s_ready_o     = (r_state == SCAN);
    assign busy_o        = (r_state == SCAN);
    assign valid_o       = (r_state == DONE);
    assign left_f1_o     = r_left_f1;
    assign left_f2_o     = r_left_f2;
    assign right_f1_o    = r_right_f1;
    assign right_f2_o    = r_right_f2;
    assign left_l1_o     = r_left_l1;
    assign left_l2_o     = r_left_l2;
    assign right_l1_o    = r_right_l1;
    assign right_l2_o    = r_right_l2;
    assign left_found_o  = r_left_found;
    assign right_found_o = r_right_found;
    assign bw_o          = r_bw;
`ifdef FIND_BW_EDGES_PEAK_EN
    assign peak_bin_o    = r_peak_bin;
    assign peak_val_o    = r_peak_val;
`endif
endmodule
